// File: rtl/frame_pkg.sv
// frame_pkg: grid geometry, command opcodes and writer states shared with Frame.
package frame_pkg;
   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int CHAR_W = 5;
   localparam logic [5:0] COL_MAX = 6'(COLS - 1);
   localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
   typedef enum logic [1:0] {OP_PUT, OP_NEWLINE, OP_CLEAR, OP_GOTO} op_t;
   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINE_CLR} state_t;
   function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] m);
      return v > m ? m : v;
   endfunction
   function automatic logic [5:0] next_row(input logic [5:0] r);
      return r == ROW_MAX ? 6'd0 : r + 6'd1;
   endfunction
endpackage

// File: rtl/frame_text_writer_if.sv
// frame_text_writer_if: valid/ready console command stream.
interface frame_text_writer_if;
   import frame_pkg::*;
   logic in_valid;
   logic in_ready;
   op_t in_op;
   logic [CHAR_W-1:0] in_char;
   logic [5:0] in_x;
   logic [5:0] in_y;
   modport master(output in_valid, in_op, in_char, in_x, in_y, input in_ready);
   modport slave(input in_valid, in_op, in_char, in_x, in_y, output in_ready);
endinterface

// File: rtl/frame_cell_walker.sv
// frame_cell_walker: row-major cell walk over the whole grid or a single row.
module frame_cell_walker
   import frame_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       row_only,
   input  logic       step,
   input  logic [5:0] start_row,
   output logic [5:0] col,
   output logic [5:0] row,
   output logic       done
);
   logic row_mode;
   assign done = step && col == COL_MAX && (row_mode || row == ROW_MAX);
   always_ff @(posedge clk) begin
      if (reset) begin
         col <= '0;
         row <= '0;
         row_mode <= 1'b0;
      end else if (start) begin
         col <= '0;
         row <= start_row;
         row_mode <= row_only;
      end else if (step) begin
         col <= col == COL_MAX ? 6'd0 : col + 6'd1;
         row <= col == COL_MAX && !row_mode ? next_row(row) : row;
      end
   end
endmodule

// File: rtl/frame_text_writer.sv
// frame_text_writer: console command stream to Frame character-grid writes.
module frame_text_writer
   import frame_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   frame_text_writer_if.slave cmd,
   output logic [5:0]        x,
   output logic [5:0]        y,
   output logic [CHAR_W-1:0] char_code,
   output logic              we,
   output logic [5:0]        cursor_x,
   output logic [5:0]        cursor_y
);
   state_t state;
   logic [5:0] col, row, nl_y;
   logic done, accept, wrap, walk_start;
   assign cmd.in_ready = state == S_IDLE;
   assign accept = cmd.in_valid && cmd.in_ready;
   assign nl_y = next_row(cursor_y);
   assign wrap = cursor_x == COL_MAX;
   assign walk_start = accept && (cmd.in_op == OP_NEWLINE || cmd.in_op == OP_CLEAR ||
                                  (cmd.in_op == OP_PUT && wrap));
   frame_cell_walker u_walker (
      .clk(clk),
      .reset(reset),
      .start(walk_start),
      .row_only(cmd.in_op != OP_CLEAR),
      .step(state != S_IDLE),
      .start_row(cmd.in_op == OP_CLEAR ? 6'd0 : nl_y),
      .col(col),
      .row(row),
      .done(done)
   );
   // Both clear states emit the walker cell; a PUT overrides the write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_CLEAR;
         cursor_x <= '0;
         cursor_y <= '0;
         x <= '0;
         y <= '0;
         char_code <= '0;
         we <= 1'b0;
      end else begin
         we <= state != S_IDLE;
         x <= col;
         y <= row;
         char_code <= '0;
         if (done) begin
            state <= S_IDLE;
            if (state == S_CLEAR) {cursor_x, cursor_y} <= '0;
         end
         if (accept) begin
            case (cmd.in_op)
               OP_PUT: begin
                  we <= 1'b1;
                  x <= cursor_x;
                  y <= cursor_y;
                  char_code <= cmd.in_char;
                  cursor_x <= wrap ? 6'd0 : cursor_x + 6'd1;
                  if (wrap) begin
                     cursor_y <= nl_y;
                     state <= S_LINE_CLR;
                  end
               end
               OP_NEWLINE: begin
                  cursor_x <= '0;
                  cursor_y <= nl_y;
                  state <= S_LINE_CLR;
               end
               OP_CLEAR: state <= S_CLEAR;
               default: begin
                  cursor_x <= clamp(cmd.in_x, COL_MAX);
                  cursor_y <= clamp(cmd.in_y, ROW_MAX);
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_frame_text_writer.sv
// tb_frame_text_writer: random command stream checked against a queue-of-writes screen model.
module tb_frame_text_writer;
   import frame_pkg::*;
   typedef logic [11+CHAR_W:0] wr_t;
   localparam int LIM = COLS * ROWS + 50;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [5:0] x, y, cursor_x, cursor_y;
   logic [CHAR_W-1:0] char_code;
   logic we;
   int n_cmp = 0;
   int n_bad = 0;
   wr_t exp_q[$];
   int mx = 0;
   int my = 0;
   int exp_busy = 0;
   frame_text_writer_if cmd();
   frame_text_writer dut (
      .clk(clk),
      .reset(reset),
      .cmd(cmd),
      .x(x),
      .y(y),
      .char_code(char_code),
      .we(we),
      .cursor_x(cursor_x),
      .cursor_y(cursor_y)
   );
   always #10 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   function automatic void push_row(input int r);
      for (int c = 0; c < COLS; c++) exp_q.push_back({6'(c), 6'(r), {CHAR_W{1'b0}}});
   endfunction
   function automatic void push_all();
      for (int r = 0; r < ROWS; r++) push_row(r);
      mx = 0;
      my = 0;
   endfunction
   // Screen-level meaning of each command: writes it produces and where the cursor lands.
   function automatic void model(input op_t op, input logic [CHAR_W-1:0] ch, input int ix, input int iy);
      exp_busy = 0;
      case (op)
         OP_PUT: begin
            exp_q.push_back({6'(mx), 6'(my), ch});
            mx++;
            if (mx == COLS) begin
               mx = 0;
               my = (my + 1) % ROWS;
               push_row(my);
               exp_busy = COLS;
            end
         end
         OP_NEWLINE: begin
            mx = 0;
            my = (my + 1) % ROWS;
            push_row(my);
            exp_busy = COLS;
         end
         OP_CLEAR: begin
            push_all();
            exp_busy = COLS * ROWS;
         end
         default: begin
            mx = ix < COLS ? ix : COLS - 1;
            my = iy < ROWS ? iy : ROWS - 1;
         end
      endcase
   endfunction
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (exp_q.size() == 0) check("spurious_we", 1, 0);
         else check("wr", {x, y, char_code}, exp_q.pop_front());
      end
   end
   task automatic send(input op_t op, input logic [CHAR_W-1:0] ch, input logic [5:0] ix, input logic [5:0] iy);
      int busy = 0;
      check("ready_pre", cmd.in_ready, 1);
      cmd.in_valid = 1'b1;
      cmd.in_op = op;
      cmd.in_char = ch;
      cmd.in_x = ix;
      cmd.in_y = iy;
      @(posedge clk);
      model(op, ch, int'(ix), int'(iy));
      #1 cmd.in_valid = 1'b0;
      @(negedge clk);
      while (!cmd.in_ready && busy < LIM) begin
         busy++;
         @(negedge clk);
      end
      check("busy", busy, exp_busy);
      check("cur_x", cursor_x, mx);
      check("cur_y", cursor_y, my);
   endtask
   task automatic release_reset();
      int n = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      push_all();
      do begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1) check("first_we", we, 1);
      end while (!cmd.in_ready && n < LIM);
      check("clr_cycles", n, COLS * ROWS);
      check("clr_cur", {cursor_x, cursor_y}, 0);
   endtask
   initial begin
      cmd.in_valid = 1'b0;
      cmd.in_op = OP_PUT;
      cmd.in_char = '0;
      cmd.in_x = '0;
      cmd.in_y = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", we, 0);
      check("rst_xyc", {x, y, char_code}, 0);
      check("rst_ready", cmd.in_ready, 0);
      check("rst_cur", {cursor_x, cursor_y}, 0);
      release_reset();
      send(OP_PUT, 5'd5, 6'd0, 6'd0);
      send(OP_GOTO, 5'd0, 6'd0, 6'd0);
      repeat (COLS) send(OP_PUT, 5'd3, 6'd0, 6'd0);
      send(OP_GOTO, 5'd0, 6'd39, 6'd29);
      send(OP_PUT, 5'd7, 6'd0, 6'd0);
      send(OP_GOTO, 5'd0, 6'd50, 6'd31);
      send(OP_NEWLINE, 5'd9, 6'd0, 6'd0);
      send(OP_CLEAR, 5'd4, 6'd0, 6'd0);
      for (int i = 0; i < 400; i++) begin
         int r = $urandom_range(0, 39);
         op_t op = r < 26 ? OP_PUT : r < 31 ? OP_NEWLINE : r < 38 ? OP_GOTO : OP_CLEAR;
         send(op, 5'($urandom), 6'($urandom), 6'($urandom));
      end
      send(OP_GOTO, 5'd0, 6'd10, 6'd4);
      cmd.in_valid = 1'b1;
      cmd.in_op = OP_NEWLINE;
      @(posedge clk);
      model(OP_NEWLINE, 5'd0, 0, 0);
      #1 cmd.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 exp_q.delete();
      check("abort_we", we, 0);
      check("abort_ready", cmd.in_ready, 0);
      check("abort_cur", {cursor_x, cursor_y}, 0);
      release_reset();
      send(OP_PUT, 5'd31, 6'd0, 6'd0);
      repeat (3) @(negedge clk);
      check("drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
